// File: rtl/edge_pkg.sv
// Shared types and constants for the edge_stream Sobel edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_MAG = 2'd0,
        EDGE_BIN = 2'd1,
        EDGE_INV = 2'd2
    } edgeMode_e;

    localparam int PIPE_DEPTH = 3;

    // Signed width wide enough for a 3x3 Sobel gradient of PIX_W-bit pixels.
    function automatic int gradWidth(input int pixW);
        return pixW + 3;
    endfunction

endpackage

// File: rtl/edge_stream_if.sv
// Pixel stream bus into and out of edge_stream; the master drives RGB pixels, the slave returns edges.
interface edge_stream_if #(
    parameter int PIX_W = 8
);
    logic             iDVAL;
    logic             iSOF;
    logic [PIX_W-1:0] iR;
    logic [PIX_W-1:0] iG;
    logic [PIX_W-1:0] iB;
    logic [1:0]       iMode;
    logic [PIX_W-1:0] iThresh;
    logic             oDVAL;
    logic [PIX_W-1:0] oEdge;

    modport master (
        output iDVAL, iSOF, iR, iG, iB, iMode, iThresh,
        input  oDVAL, oEdge
    );

    modport slave (
        input  iDVAL, iSOF, iR, iG, iB, iMode, iThresh,
        output oDVAL, oEdge
    );
endinterface

// File: rtl/edge_line_buffer.sv
// One line of grayscale history: single clock, one read and one write port, read-before-write.
module edge_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Read port; a same-address write in this cycle is not yet visible here.
    always_ff @(posedge clk) begin
        if (rdEn) begin
            rdData <= mem_r[rdAddr];
        end
    end

endmodule

// File: rtl/edge_stream.sv
// Streaming 3x3 Sobel edge detector: RGB -> gray -> line buffers -> window -> edge, 3-cycle latency.
// Optional threshold/inverted output modes are built only when EDGE_THRESH_EN is defined.
module edge_stream
    import edge_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic          iCLK,
    input logic          iRST_N,
    edge_stream_if.slave bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int GW = gradWidth(PIX_W);
    localparam int SW = PIX_W + 2;

    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [XW-1:0]     curX_s;
    logic [YW-1:0]     curY_s;
    logic [SW-1:0]     rgbSum_s;
    logic [PIX_W-1:0]  gray_s;

    logic              s1Valid_r;
    logic [PIX_W-1:0]  s1Gray_r;
    logic [XW-1:0]     s1X_r;
    logic [YW-1:0]     s1Y_r;
    logic [PIX_W-1:0]  lineARd_s;
    logic [PIX_W-1:0]  lineBRd_s;

    logic              s2Valid_r;
    logic              s2Border_r;
    logic [PIX_W-1:0]  win_r [3][3];

    logic signed [GW-1:0] gx_s;
    logic signed [GW-1:0] gy_s;
    logic [GW-1:0]     absGx_s;
    logic [GW-1:0]     absGy_s;
    logic [GW:0]       magSum_s;
    logic [GW-1:0]     magHalf_s;
    logic [PIX_W-1:0]  mag_s;
    logic [PIX_W-1:0]  modeEdge_s;

    logic              oDval_r;
    logic [PIX_W-1:0]  oEdge_r;

    function automatic logic signed [GW-1:0] widen(input logic [PIX_W-1:0] p);
        return signed'({{(GW-PIX_W){1'b0}}, p});
    endfunction

    // Coordinates of the incoming pixel (SOF forces the origin) and its exact grayscale value.
    always_comb begin
        curX_s   = bus.iSOF ? {XW{1'b0}} : x_r;
        curY_s   = bus.iSOF ? {YW{1'b0}} : y_r;
        rgbSum_s = SW'(bus.iR) + SW'(bus.iG) + SW'(bus.iB);
        gray_s   = PIX_W'(rgbSum_s / SW'(2'd3));
    end

    // S1: raster counters and gray register.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            x_r       <= '0;
            y_r       <= '0;
            s1Valid_r <= 1'b0;
            s1Gray_r  <= '0;
            s1X_r     <= '0;
            s1Y_r     <= '0;
        end else begin
            s1Valid_r <= bus.iDVAL;
            if (bus.iDVAL) begin
                s1Gray_r <= gray_s;
                s1X_r    <= curX_s;
                s1Y_r    <= curY_s;
                if (curX_s == XW'(IMG_W - 1)) begin
                    x_r <= '0;
                    y_r <= (curY_s == YW'(IMG_H - 1)) ? {YW{1'b0}} : curY_s + YW'(1'b1);
                end else begin
                    x_r <= curX_s + XW'(1'b1);
                    y_r <= curY_s;
                end
            end
        end
    end

    // lineA holds row y-2, lineB row y-1; both age by one row as each pixel passes through S2.
    edge_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) lineA (
        .clk    (iCLK),
        .rdEn   (bus.iDVAL),
        .rdAddr (curX_s),
        .rdData (lineARd_s),
        .wrEn   (s1Valid_r),
        .wrAddr (s1X_r),
        .wrData (lineBRd_s)
    );

    edge_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) lineB (
        .clk    (iCLK),
        .rdEn   (bus.iDVAL),
        .rdAddr (curX_s),
        .rdData (lineBRd_s),
        .wrEn   (s1Valid_r),
        .wrAddr (s1X_r),
        .wrData (s1Gray_r)
    );

    // S2: shift the 3x3 window left and insert the new column.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            s2Valid_r  <= 1'b0;
            s2Border_r <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else begin
            s2Valid_r <= s1Valid_r;
            if (s1Valid_r) begin
                for (int r = 0; r < 3; r++) begin
                    win_r[r][0] <= win_r[r][1];
                    win_r[r][1] <= win_r[r][2];
                end
                win_r[0][2] <= lineARd_s;
                win_r[1][2] <= lineBRd_s;
                win_r[2][2] <= s1Gray_r;
                s2Border_r  <= (s1X_r < XW'(2'd2)) || (s1Y_r < YW'(2'd2));
            end
        end
    end

    // Sobel gradients, L1 magnitude halved and saturated to the pixel range.
    always_comb begin
        gx_s = (widen(win_r[0][2]) + (widen(win_r[1][2]) <<< 1) + widen(win_r[2][2]))
             - (widen(win_r[0][0]) + (widen(win_r[1][0]) <<< 1) + widen(win_r[2][0]));
        gy_s = (widen(win_r[2][0]) + (widen(win_r[2][1]) <<< 1) + widen(win_r[2][2]))
             - (widen(win_r[0][0]) + (widen(win_r[0][1]) <<< 1) + widen(win_r[0][2]));
        absGx_s   = gx_s[GW-1] ? unsigned'(-gx_s) : unsigned'(gx_s);
        absGy_s   = gy_s[GW-1] ? unsigned'(-gy_s) : unsigned'(gy_s);
        magSum_s  = {1'b0, absGx_s} + {1'b0, absGy_s};
        magHalf_s = GW'(magSum_s >> 1'b1);
        mag_s     = (|magHalf_s[GW-1:PIX_W]) ? {PIX_W{1'b1}} : magHalf_s[PIX_W-1:0];
    end

`ifdef EDGE_THRESH_EN
    // Output mode selection; the reserved code behaves as plain magnitude.
    always_comb begin
        modeEdge_s = mag_s;
        case (edgeMode_e'(bus.iMode))
            EDGE_BIN: modeEdge_s = (mag_s >= bus.iThresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            EDGE_INV: modeEdge_s = ~mag_s;
            default:  modeEdge_s = mag_s;
        endcase
    end
`else
    logic unusedCfg_s;
    assign unusedCfg_s = ^{bus.iMode, bus.iThresh};
    assign modeEdge_s  = mag_s;
`endif

    // S3: registered output; border pixels are forced to zero in every mode.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oDval_r <= 1'b0;
            oEdge_r <= '0;
        end else begin
            oDval_r <= s2Valid_r;
            if (s2Valid_r) begin
                oEdge_r <= s2Border_r ? {PIX_W{1'b0}} : modeEdge_s;
            end
        end
    end

    assign bus.oDVAL = oDval_r;
    assign bus.oEdge = oEdge_r;

endmodule

// File: tb/tb_edge_stream.sv
// Directed bench for edge_stream on an 8x6 image: flat, step and ramp frames, gaps, mid-line SOF, reset.
module tb_edge_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int NPIX  = IMG_W * IMG_H;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cyc  = 0;
    int   nVec = 0;
    int   nBad = 0;
    int   outCnt = 0;
    int   expQ[$];
    int   issueQ[$];
    int   cnt0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    edge_stream_if #(.PIX_W(PIX_W)) bus ();

    edge_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nVec++;
        if (obs != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hand-derived edge values: flat -> 0, step between columns 3|4 -> 255 at x=4,5, ramp 10*x -> 40.
    function automatic int expEdge(input int kind, input int x, input int y, input int mode, input int thr);
        int mag;
        if (x < 2 || y < 2) return 0;
        case (kind)
            0:       mag = 0;
            1:       mag = (x == 4 || x == 5) ? 255 : 0;
            default: mag = 40;
        endcase
`ifdef EDGE_THRESH_EN
        if (mode == 1) return (mag >= thr) ? 255 : 0;
        if (mode == 2) return 255 - mag;
`endif
        return mag;
    endfunction

    function automatic int pixVal(input int kind, input int x);
        case (kind)
            0:       return 100;
            1:       return (x >= 4) ? 255 : 0;
            default: return 10 * x;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            bus.iDVAL = 1'b0;
            bus.iSOF  = 1'($urandom);
            bus.iR    = 8'($urandom);
            bus.iG    = 8'($urandom);
            bus.iB    = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic drivePix(input int v, input bit sof, input int expv);
        bus.iDVAL = 1'b1;
        bus.iSOF  = sof;
        bus.iR    = 8'(v);
        bus.iG    = 8'(v);
        bus.iB    = 8'(v);
        expQ.push_back(expv);
        issueQ.push_back(cyc);
        @(posedge clk); #1;
    endtask

    task automatic sendFrame(input int kind, input int mode, input int thr, input bit gaps, input int n);
        bus.iMode   = 2'(mode);
        bus.iThresh = 8'(thr);
        for (int i = 0; i < n; i++) begin
            int x = i % IMG_W;
            int y = i / IMG_W;
            if (gaps) idle($urandom_range(0, 1));
            drivePix(pixVal(kind, x), (i == 0), expEdge(kind, x, y, mode, thr));
        end
    endtask

    // Output scoreboard: value and exact 3-cycle latency per pixel; reset discards in-flight entries.
    always @(negedge clk) begin
        if (bus.oDVAL === 1'b1) begin
            outCnt++;
            if (expQ.size() == 0) begin
                chk("spuriousOut", int'(bus.oDVAL), 0);
            end else begin
                chk("edge", int'(bus.oEdge), expQ.pop_front());
                chk("latency", cyc - issueQ.pop_front(), 3);
            end
        end
        if (rstN == 1'b0) begin
            expQ.delete();
            issueQ.delete();
        end
    end

    initial begin
        bus.iDVAL = 1'b0; bus.iSOF = 1'b0;
        bus.iR = 8'd0; bus.iG = 8'd0; bus.iB = 8'd0;
        bus.iMode = 2'd0; bus.iThresh = 8'd0;
        rstN = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rstOdval", int'(bus.oDVAL), 0);
        chk("rstOedge", int'(bus.oEdge), 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        cnt0 = outCnt;
        sendFrame(0, 0, 0, 1'b0, NPIX); idle(6);
        chk("flatCount", outCnt - cnt0, NPIX);

        sendFrame(1, 0, 0, 1'b0, NPIX); idle(6);
        sendFrame(1, 0, 0, 1'b1, NPIX); idle(6);
        sendFrame(2, 0, 0, 1'b0, NPIX); idle(6);
`ifdef EDGE_THRESH_EN
        sendFrame(2, 1, 30, 1'b0, NPIX); idle(6);
        sendFrame(2, 1, 50, 1'b0, NPIX); idle(6);
        sendFrame(2, 2, 0, 1'b0, NPIX);  idle(6);
        sendFrame(2, 3, 0, 1'b0, NPIX);  idle(6);
`else
        sendFrame(2, 1, 30, 1'b0, NPIX); idle(6);
`endif

        // Partial frame leaves the counters at (3,1); the next SOF must restart at the origin.
        for (int i = 0; i < 11; i++) drivePix(77, 1'b0, 0);
        sendFrame(1, 0, 0, 1'b0, NPIX); idle(6);

        sendFrame(2, 0, 0, 1'b0, 20);
        bus.iDVAL = 1'b0;
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstMidOdval", int'(bus.oDVAL), 0);
        chk("rstMidOedge", int'(bus.oEdge), 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        sendFrame(2, 0, 0, 1'b0, NPIX); idle(6);

        chk("drainEmpty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
